// File: rtl/prmcu_uart_rx_fifo.sv
// rtl/prmcu_uart_rx_fifo.sv - first-word-fall-through receive FIFO for the UART receiver
// Drops words on overflow (the serial line cannot be stalled) and latches a sticky overflow flag.
module prmcu_uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_en,
  input  logic                      flush_i,
  input  logic [WIDTH-1:0]          in_dat_i,
  input  logic                      in_vld_i,
  output logic                      in_rdy_o,
  output logic [WIDTH-1:0]          out_dat_o,
  output logic                      out_vld_o,
  input  logic                      out_rdy_i,
  output logic [$clog2(DEPTH):0]    level_o,
  input  logic [$clog2(DEPTH):0]    threshold_i,
  output logic                      thr_irq_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      ovf_o,
  input  logic                      ovf_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             ovf;

  logic push;
  logic pop;
  logic wr_en;
  logic ovf_evt;

  assign empty_o   = (level == '0);
  assign full_o    = (level == LVL_FULL);
  assign level_o   = level;
  assign ovf_o     = ovf;
  assign thr_irq_o = (threshold_i != '0) && (level >= threshold_i);

  assign in_rdy_o  = fifo_en & ~flush_i;
  assign out_vld_o = ~empty_o & fifo_en;
  assign out_dat_o = mem[rd_ptr];

  assign push    = in_vld_i & in_rdy_o;
  assign pop     = out_vld_o & out_rdy_i & fifo_en;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign wr_en   = push & (~full_o | pop);
  assign ovf_evt = push & full_o & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (fifo_en & flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (wr_en && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !wr_en) begin
        level <= level - LVL_ONE;
      end
    end
  end

  // Overflow wins over a same-cycle clear; the flag is frozen while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (ovf_evt) begin
      ovf <= 1'b1;
    end else if (fifo_en & ovf_clr_i) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prmcu_uart_rx_fifo.sv
// tb/tb_prmcu_uart_rx_fifo.sv - self-checking bench for prmcu_uart_rx_fifo
// Outputs are compared each cycle against a queue-based reference model.
module tb_prmcu_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_en;
  logic             flush_i;
  logic [WIDTH-1:0] in_dat_i;
  logic             in_vld_i;
  logic             in_rdy_o;
  logic [WIDTH-1:0] out_dat_o;
  logic             out_vld_o;
  logic             out_rdy_i;
  logic [4:0]       level_o;
  logic [4:0]       threshold_i;
  logic             thr_irq_o;
  logic             full_o;
  logic             empty_o;
  logic             ovf_o;
  logic             ovf_clr_i;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;

  always #5 clk = ~clk;

  prmcu_uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_en     (fifo_en),
    .flush_i     (flush_i),
    .in_dat_i    (in_dat_i),
    .in_vld_i    (in_vld_i),
    .in_rdy_o    (in_rdy_o),
    .out_dat_o   (out_dat_o),
    .out_vld_o   (out_vld_o),
    .out_rdy_i   (out_rdy_i),
    .level_o     (level_o),
    .threshold_i (threshold_i),
    .thr_irq_o   (thr_irq_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int n;
    logic vld;
    n   = mq.size();
    vld = fifo_en && (n > 0);
    chk("level", level_o, n);
    chk("empty", empty_o, n == 0);
    chk("full", full_o, n == DEPTH);
    chk("out_vld", out_vld_o, vld);
    chk("in_rdy", in_rdy_o, fifo_en & ~flush_i);
    chk("ovf", ovf_o, m_ovf);
    chk("thr_irq", thr_irq_o, (threshold_i != 0) && (n >= int'(threshold_i)));
    if (vld) chk("out_dat", out_dat_o, mq[0]);
  endtask

  task automatic model_step();
    int n;
    logic p, q, evt;
    n   = mq.size();
    p   = in_vld_i & fifo_en & ~flush_i;
    q   = fifo_en & out_rdy_i & (n > 0);
    evt = 1'b0;
    if (fifo_en & flush_i) begin
      mq.delete();
    end else begin
      if (q) void'(mq.pop_front());
      if (p) begin
        if (n < DEPTH || q) mq.push_back(in_dat_i);
        else evt = 1'b1;
      end
    end
    if (evt) m_ovf = 1'b1;
    else if (fifo_en & ovf_clr_i) m_ovf = 1'b0;
  endtask

  task automatic cycle(input logic en, input logic fl, input logic vl,
                       input logic [WIDTH-1:0] d, input logic rd, input logic cl);
    fifo_en   = en;
    flush_i   = fl;
    in_vld_i  = vl;
    in_dat_i  = d;
    out_rdy_i = rd;
    ovf_clr_i = cl;
    #1;
    check_model();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    fifo_en = 1'b1; flush_i = 1'b0; in_vld_i = 1'b0; out_rdy_i = 1'b0; ovf_clr_i = 1'b0;
    #1;
  endtask

  initial begin
    int pushed;
    int guard;
    rst = 1'b0; fifo_en = 1'b0; flush_i = 1'b0; in_dat_i = '0; in_vld_i = 1'b0;
    out_rdy_i = 1'b0; threshold_i = '0; ovf_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    fifo_en = 1'b1; #1;
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_vld", out_vld_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_thr", thr_irq_o, 0);
    rst = 1'b1;
    @(negedge clk);

    // Fill / drain, first-word latency
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 1, 9'(i), 0, 0);
      if (i == 0) chk("latency_vld", out_vld_o, 1);
    end
    settle();
    chk("fill_full", full_o, 1);
    chk("fill_level", level_o, 16);
    // Overflow drop and clear
    cycle(1, 0, 1, 9'h1AA, 0, 0);
    settle();
    chk("ovf_set", ovf_o, 1);
    chk("ovf_level", level_o, 16);
    cycle(1, 0, 0, 9'h000, 0, 1);
    settle();
    chk("ovf_clr", ovf_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("drain_order", out_dat_o, 9'(i));
      cycle(1, 0, 0, 9'h000, 1, 0);
    end
    settle();
    chk("drain_empty", empty_o, 1);

    // Simultaneous push and pop at full
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 1, 9'(9'h040 + i), 0, 0);
    cycle(1, 0, 1, 9'h155, 1, 0);
    settle();
    chk("simul_level", level_o, 16);
    chk("simul_ovf", ovf_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      if (i == 15) chk("simul_16th", out_dat_o, 9'h155);
      cycle(1, 0, 0, 9'h000, 1, 0);
    end

    // Threshold
    threshold_i = 5'd4;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("thr_below", thr_irq_o, 0);
      cycle(1, 0, 1, 9'(9'h0A0 + i), 0, 0);
    end
    settle();
    chk("thr_rise", thr_irq_o, 1);
    cycle(1, 0, 0, 9'h000, 1, 0);
    settle();
    chk("thr_fall", thr_irq_o, 0);
    threshold_i = 5'd0;
    for (int i = 0; i < 14; i++) cycle(1, 0, 1, 9'($urandom), 0, 0);
    settle();
    chk("thr_zero", thr_irq_o, 0);

    // Flush with 5 stored, overriding a same-cycle push and pop
    cycle(1, 1, 0, 9'h000, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 9'(9'h060 + i), 0, 0);
    cycle(1, 1, 1, 9'h0FF, 1, 0);
    settle();
    chk("flush_level", level_o, 0);
    chk("flush_empty", empty_o, 1);
    cycle(1, 0, 1, 9'h033, 0, 0);
    settle();
    chk("flush_next", out_dat_o, 9'h033);
    cycle(1, 0, 0, 9'h000, 1, 0);

    // Asynchronous reset mid-cycle with 5 stored
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 9'(9'h070 + i), 0, 0);
    settle();
    rst = 1'b0; #1;
    chk("arst_level", level_o, 0);
    chk("arst_empty", empty_o, 1);
    chk("arst_vld", out_vld_o, 0);
    mq.delete(); m_ovf = 1'b0;
    rst = 1'b1;
    cycle(1, 0, 1, 9'h033, 0, 0);
    settle();
    chk("arst_next", out_dat_o, 9'h033);
    cycle(1, 0, 0, 9'h000, 1, 0);

    // 40-word stream across pointer wrap with random consumer
    threshold_i = 5'd6;
    pushed = 0;
    guard  = 0;
    while ((pushed < 40 || mq.size() > 0) && guard < 2000) begin
      logic vl;
      vl = (pushed < 40) && ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH);
      if (vl) pushed++;
      cycle(1, 0, vl, 9'($urandom), 1'($urandom), 0);
      guard++;
    end
    chk("stream_done", guard < 2000, 1);

    // Free-running random mix including disable, flush, overflow and clear
    for (int i = 0; i < 400; i++) begin
      threshold_i = 5'($urandom_range(0, 16));
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0, 1'($urandom),
            9'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prmcu_uart_rx_fifo.md
PRMCU_UART_RX_FIFO -- requirements
Module: prmcu_uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of stored words; it SHALL be a power of 2, range 4..64.
REQ-002 SHALL have parameter WIDTH, default 9, meaning the word width, matching the UART receiver out_dat_o.
REQ-003 SHALL have port clk, in, 1, the single clock; all state SHALL be sampled on its rising edge.
REQ-004 SHALL have port rst, in, 1, the reset; it SHALL be asynchronous and active-low.
REQ-005 SHALL have port fifo_en, in, 1, block enable; while 0, no push and no pop SHALL occur.
REQ-006 SHALL have port flush_i, in, 1, a synchronous clear of the contents.
REQ-007 SHALL have port in_dat_i, in, WIDTH, the received word from the UART receiver.
REQ-008 SHALL have port in_vld_i, in, 1, the received word is valid.
REQ-009 SHALL have port in_rdy_o, out, 1, the FIFO accepts a word.
REQ-010 SHALL have port out_dat_o, out, WIDTH, the head-of-queue word.
REQ-011 SHALL have port out_vld_o, out, 1, the head word is valid.
REQ-012 SHALL have port out_rdy_i, in, 1, the consumer takes the head word.
REQ-013 SHALL have port level_o, out, log2(DEPTH)+1, the current occupancy.
REQ-014 SHALL have port threshold_i, in, log2(DEPTH)+1, the interrupt fill threshold.
REQ-015 SHALL have port thr_irq_o, out, 1, asserted while level_o >= threshold_i and threshold_i != 0.
REQ-016 SHALL have port full_o, out, 1, asserted when level_o == DEPTH.
REQ-017 SHALL have port empty_o, out, 1, asserted when level_o == 0.
REQ-018 SHALL have port ovf_o, out, 1, a sticky overflow flag.
REQ-019 SHALL have port ovf_clr_i, in, 1, clears ovf_o.

Function
REQ-020 push = in_vld_i & in_rdy_o; pop = out_vld_o & out_rdy_i & fifo_en.
REQ-021 in_rdy_o SHALL equal fifo_en & ~flush_i; the receiver is never stalled, because the serial line cannot be back-pressured.
REQ-022 A push with level_o < DEPTH, or a push with level_o == DEPTH and a pop in the same cycle, SHALL write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
REQ-023 A push with level_o == DEPTH and no pop SHALL drop the word, leave the pointers and level unchanged, and set ovf_o at the next edge.
REQ-024 The FIFO SHALL be first-word-fall-through: out_vld_o = ~empty_o & fifo_en, and out_dat_o = mem[rd_ptr] with no extra register stage.
REQ-025 Latency: a word pushed at edge N SHALL be visible on out_vld_o/out_dat_o after edge N, i.e. in cycle N+1, when the FIFO was empty.
REQ-026 A pop SHALL increment rd_ptr modulo DEPTH; a pop with empty_o = 1 is impossible, because out_vld_o = 0.
REQ-027 level_o SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (including at full and at empty+1).
REQ-028 Pointers SHALL be log2(DEPTH) bits and wrap DEPTH-1 -> 0 without a gap; level SHALL never exceed DEPTH or underflow.
REQ-029 flush_i = 1 SHALL zero wr_ptr, rd_ptr and level at the next edge, overriding any push or pop in that cycle; ovf_o SHALL be unaffected.
REQ-030 ovf_clr_i = 1 SHALL clear ovf_o; a simultaneous overflow event SHALL win, leaving ovf_o = 1.
REQ-031 fifo_en = 0 SHALL freeze the contents, pointers and ovf_o, and force in_rdy_o = 0 and out_vld_o = 0.
REQ-032 thr_irq_o, full_o and empty_o SHALL be combinational on the registered level and threshold_i.
REQ-033 The memory contents SHALL NOT be reset; only the pointers, level and flags SHALL be reset.

Reset
REQ-034 rst = 0 SHALL immediately force wr_ptr = 0, rd_ptr = 0, level_o = 0, ovf_o = 0, empty_o = 1, full_o = 0, out_vld_o = 0 and thr_irq_o = 0.
REQ-035 A reset asserted mid-operation SHALL discard all stored words; after release, the first pushed word SHALL be the first popped word.
REQ-036 Reset release SHALL take effect synchronously; the first push SHALL be accepted at the first rising edge with rst = 1.

Verification
REQ-037 Fill/drain: with DEPTH = 16, out_rdy_i = 0, push 0x000..0x00F -> full_o = 1, level_o = 16; then out_rdy_i = 1 -> 0x000..0x00F out in order, then empty_o = 1.
REQ-038 Overflow: with the FIFO full, push 0x1AA -> ovf_o = 1, level_o = 16, 0x1AA never appears; ovf_clr_i pulse -> ovf_o = 0.
REQ-039 Simultaneous at full: with level 16, push 0x155 and pop in the same cycle -> level_o stays 16, ovf_o = 0, 0x155 is popped 16th afterwards.
REQ-040 Wrap and latency: 40 words streamed with random out_rdy_i -> order preserved across pointer wrap; first-word out_vld_o goes high one cycle after the push.
REQ-041 Threshold: threshold_i = 4 -> thr_irq_o rises on the 4th push and falls on the pop that brings level_o to 3; threshold_i = 0 -> thr_irq_o never asserts.
REQ-042 Reset/flush: with 5 words stored, assert flush_i (or pulse rst low mid-cycle) -> level_o = 0 and empty_o = 1; the next push 0x033 is the next word popped.
